// File: rtl/maze_move_checker_if.sv
// Bundle between the ball stage, the maze map ROM and the renderer/game logic.
// The checker sits on the slave side; the environment drives the master side.
interface maze_move_checker_if #(
    parameter int GRID_BITS = 4
);
    logic [7:0]             x_in;
    logic [7:0]             y_in;
    logic [2*GRID_BITS-1:0] map_addr;
    logic [1:0]             map_data;
    logic [7:0]             x_out;
    logic [7:0]             y_out;
    logic                   move_ok;
    logic                   move_blocked;
    logic                   fell_in_hole;
    logic                   goal_reached;
    logic [15:0]            move_count;

    modport slave (
        input  x_in, y_in, map_data,
        output map_addr, x_out, y_out, move_ok, move_blocked,
               fell_in_hole, goal_reached, move_count
    );

    modport master (
        output x_in, y_in, map_data,
        input  map_addr, x_out, y_out, move_ok, move_blocked,
               fell_in_hole, goal_reached, move_count
    );
endinterface

// File: rtl/maze_move_checker.sv
// Judges each new ball proposal against the maze map ROM and commits legal moves.
// One lookup takes three cycles: capture in IDLE, ROM read in READ, verdict in DECIDE.
module maze_move_checker #(
    parameter int GRID_BITS = 4,
    parameter int START_X   = 0,
    parameter int START_Y   = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    maze_move_checker_if.slave   bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_READ   = 2'd1;
    localparam logic [1:0] ST_DECIDE = 2'd2;

    localparam logic [1:0] CELL_FREE = 2'd0;
    localparam logic [1:0] CELL_WALL = 2'd1;
    localparam logic [1:0] CELL_GOAL = 2'd2;
    localparam logic [1:0] CELL_HOLE = 2'd3;

    localparam logic [7:0] START_X_C = 8'(START_X);
    localparam logic [7:0] START_Y_C = 8'(START_Y);

    logic [1:0]             state_r;
    logic [15:0]            last_req_r;
    logic [7:0]             req_x_r;
    logic [7:0]             req_y_r;
    logic [2*GRID_BITS-1:0] map_addr_r;
    logic [7:0]             x_out_r;
    logic [7:0]             y_out_r;
    logic                   move_ok_r;
    logic                   move_blocked_r;
    logic                   fell_in_hole_r;
    logic                   goal_reached_r;
    logic [15:0]            move_count_r;

    logic [15:0]            req_s;
    logic                   req_changed_s;
    logic                   out_of_range_s;
    logic [2*GRID_BITS-1:0] addr_s;
    logic [15:0]            count_next_s;

    // Proposal decode: change detection, range check, ROM address and saturating count.
    always_comb begin
        req_s         = {bus.x_in, bus.y_in};
        req_changed_s = (req_s != last_req_r);
        addr_s        = {bus.y_in[GRID_BITS-1:0], bus.x_in[GRID_BITS-1:0]};
        if (((bus.x_in >> GRID_BITS) != 8'd0) || ((bus.y_in >> GRID_BITS) != 8'd0)) begin
            out_of_range_s = 1'b1;
        end else begin
            out_of_range_s = 1'b0;
        end
        if (move_count_r == 16'hFFFF) begin
            count_next_s = move_count_r;
        end else begin
            count_next_s = move_count_r + 16'd1;
        end
    end

    // Lookup sequencer and committed game state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            last_req_r     <= {START_X_C, START_Y_C};
            req_x_r        <= START_X_C;
            req_y_r        <= START_Y_C;
            map_addr_r     <= {(2*GRID_BITS){1'b0}};
            x_out_r        <= START_X_C;
            y_out_r        <= START_Y_C;
            move_ok_r      <= 1'b0;
            move_blocked_r <= 1'b0;
            fell_in_hole_r <= 1'b0;
            goal_reached_r <= 1'b0;
            move_count_r   <= 16'd0;
        end else begin
            move_ok_r      <= 1'b0;
            move_blocked_r <= 1'b0;
            fell_in_hole_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_changed_s) begin
                        last_req_r <= req_s;
                        // A frozen game or an off-grid target is rejected without touching the ROM.
                        if (goal_reached_r || out_of_range_s) begin
                            move_blocked_r <= 1'b1;
                        end else begin
                            req_x_r    <= bus.x_in;
                            req_y_r    <= bus.y_in;
                            map_addr_r <= addr_s;
                            state_r    <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    state_r <= ST_DECIDE;
                end
                ST_DECIDE: begin
                    state_r <= ST_IDLE;
                    case (bus.map_data)
                        CELL_FREE: begin
                            x_out_r      <= req_x_r;
                            y_out_r      <= req_y_r;
                            move_ok_r    <= 1'b1;
                            move_count_r <= count_next_s;
                        end
                        CELL_WALL: begin
                            move_blocked_r <= 1'b1;
                        end
                        CELL_GOAL: begin
                            x_out_r        <= req_x_r;
                            y_out_r        <= req_y_r;
                            move_ok_r      <= 1'b1;
                            move_count_r   <= count_next_s;
                            goal_reached_r <= 1'b1;
                        end
                        CELL_HOLE: begin
                            x_out_r        <= START_X_C;
                            y_out_r        <= START_Y_C;
                            fell_in_hole_r <= 1'b1;
                        end
                        default: begin
                            move_blocked_r <= 1'b1;
                        end
                    endcase
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.map_addr     = map_addr_r;
    assign bus.x_out        = x_out_r;
    assign bus.y_out        = y_out_r;
    assign bus.move_ok      = move_ok_r;
    assign bus.move_blocked = move_blocked_r;
    assign bus.fell_in_hole = fell_in_hole_r;
    assign bus.goal_reached = goal_reached_r;
    assign bus.move_count   = move_count_r;

endmodule

// File: tb/tb_maze_move_checker.sv
// Directed bench for maze_move_checker with a synchronous maze ROM model.
module tb_maze_move_checker;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;
    int   pulse_cnt;
    logic [1:0] rom [0:255];

    maze_move_checker_if #(.GRID_BITS(4)) bus ();

    maze_move_checker #(.GRID_BITS(4), .START_X(0), .START_Y(0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM: data follows the address by one clock.
    always @(posedge clk) bus.map_data <= rom[bus.map_addr];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        pulse_cnt += int'(bus.move_ok) + int'(bus.move_blocked) + int'(bus.fell_in_hole);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        pulse_cnt = 0;
        for (int i = 0; i < 256; i++) rom[i] = 2'd0;
        rom[8'h11] = 2'd1;
        rom[8'h02] = 2'd3;
        rom[8'h03] = 2'd2;
        bus.x_in = 8'd0;
        bus.y_in = 8'd0;
        bus.map_data = 2'd0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;

        chk("rst_x", {8'd0, bus.x_out}, 16'd0);
        chk("rst_y", {8'd0, bus.y_out}, 16'd0);
        chk("rst_addr", {8'd0, bus.map_addr}, 16'd0);
        chk("rst_pulses", {13'd0, bus.move_ok, bus.move_blocked, bus.fell_in_hole}, 16'd0);
        chk("rst_goal", {15'd0, bus.goal_reached}, 16'd0);
        chk("rst_count", bus.move_count, 16'd0);

        // Free cell (1,0)
        bus.x_in = 8'd1;
        step();
        chk("free_addr", {8'd0, bus.map_addr}, 16'h0001);
        chk("free_early", {15'd0, bus.move_ok}, 16'd0);
        step();
        chk("free_n2", {15'd0, bus.move_ok}, 16'd0);
        step();
        chk("free_x", {8'd0, bus.x_out}, 16'd1);
        chk("free_ok", {15'd0, bus.move_ok}, 16'd1);
        chk("free_cnt", bus.move_count, 16'd1);
        step();
        chk("free_ok_end", {15'd0, bus.move_ok}, 16'd0);

        // Wall cell (1,1), then hold it
        bus.y_in = 8'd1;
        step();
        step();
        step();
        chk("wall_blk", {15'd0, bus.move_blocked}, 16'd1);
        chk("wall_ok", {15'd0, bus.move_ok}, 16'd0);
        chk("wall_x", {8'd0, bus.x_out}, 16'd1);
        chk("wall_y", {8'd0, bus.y_out}, 16'd0);
        pulse_cnt = 0;
        for (int i = 0; i < 10; i++) step();
        chk("wall_hold_pulses", 16'(pulse_cnt), 16'd0);
        chk("wall_hold_addr", {8'd0, bus.map_addr}, 16'h0011);

        // Hole cell (2,0)
        bus.x_in = 8'd2;
        bus.y_in = 8'd0;
        step();
        step();
        step();
        chk("hole_fell", {15'd0, bus.fell_in_hole}, 16'd1);
        chk("hole_x", {8'd0, bus.x_out}, 16'd0);
        chk("hole_y", {8'd0, bus.y_out}, 16'd0);
        chk("hole_cnt", bus.move_count, 16'd1);
        chk("hole_ok", {15'd0, bus.move_ok}, 16'd0);
        step();
        chk("hole_fell_end", {15'd0, bus.fell_in_hole}, 16'd0);

        // Out of range x=0x10
        bus.x_in = 8'h10;
        step();
        chk("oor_blk", {15'd0, bus.move_blocked}, 16'd1);
        chk("oor_addr", {8'd0, bus.map_addr}, 16'h0002);
        chk("oor_x", {8'd0, bus.x_out}, 16'd0);
        step();
        chk("oor_blk_end", {15'd0, bus.move_blocked}, 16'd0);

        // 1 -> 2 -> 3 on consecutive cycles: only 1 then 3 are judged
        bus.x_in = 8'd1;
        step();
        chk("burst_addr1", {8'd0, bus.map_addr}, 16'h0001);
        bus.x_in = 8'd2;
        step();
        chk("burst_addr_hold", {8'd0, bus.map_addr}, 16'h0001);
        bus.x_in = 8'd3;
        step();
        chk("burst_x1", {8'd0, bus.x_out}, 16'd1);
        chk("burst_ok1", {15'd0, bus.move_ok}, 16'd1);
        chk("burst_cnt1", bus.move_count, 16'd2);
        step();
        chk("burst_addr3", {8'd0, bus.map_addr}, 16'h0003);
        step();
        step();
        chk("goal_x", {8'd0, bus.x_out}, 16'd3);
        chk("goal_ok", {15'd0, bus.move_ok}, 16'd1);
        chk("goal_lvl", {15'd0, bus.goal_reached}, 16'd1);
        chk("goal_cnt", bus.move_count, 16'd3);

        // Frozen after goal
        step();
        bus.x_in = 8'd4;
        step();
        chk("frz_blk", {15'd0, bus.move_blocked}, 16'd1);
        chk("frz_addr", {8'd0, bus.map_addr}, 16'h0003);
        chk("frz_x", {8'd0, bus.x_out}, 16'd3);
        step();
        step();
        chk("frz_cnt", bus.move_count, 16'd3);
        chk("frz_goal", {15'd0, bus.goal_reached}, 16'd1);

        // Reset, start a lookup of (4,0), then reset again while in READ
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst2_goal", {15'd0, bus.goal_reached}, 16'd0);
        chk("rst2_cnt", bus.move_count, 16'd0);
        chk("rst2_x", {8'd0, bus.x_out}, 16'd0);
        step();
        chk("rd_addr", {8'd0, bus.map_addr}, 16'h0004);
        reset = 1'b1;
        bus.x_in = 8'd0;
        step();
        reset = 1'b0;
        chk("abort_addr", {8'd0, bus.map_addr}, 16'd0);
        chk("abort_x", {8'd0, bus.x_out}, 16'd0);
        chk("abort_pulses", {13'd0, bus.move_ok, bus.move_blocked, bus.fell_in_hole}, 16'd0);
        pulse_cnt = 0;
        for (int i = 0; i < 4; i++) step();
        chk("abort_quiet", 16'(pulse_cnt), 16'd0);
        chk("abort_cnt", bus.move_count, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
